// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder
//   Turns raw PS/2 scan bytes into single key events. Bytes arrive from a
//   receiver running off the PS/2 clock. The E0 (extended), F0 (break) and
//   E1 (pause) prefixes are folded into one event each. Events are queued in
//   a first-word fall-through FIFO with a valid/ready handshake.
//
//   Optional build macro: PS2_TYPEMATIC_FILTER_EN
//     When defined, a repeated make of the key that was last pressed (and not
//     yet released) is dropped, so auto-repeat is suppressed.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   scan_ready  receiver byte-valid level (asynchronous to clk)
//   scan_code   receiver byte, stable while scan_ready is high
//   evt_valid   FIFO head holds an event
//   evt_ready   consumer takes the head when evt_valid && evt_ready
//   evt_code    key code with prefixes stripped
//   evt_ext     event was E0-prefixed
//   evt_break   key release
//   evt_sys     device/system byte rather than a key
//   overflow    sticky; an event was dropped because the FIFO was full
//   fifo_count  number of entries held
module ps2_scan_decoder #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       scan_ready,
    input  logic [7:0]                 scan_code,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [7:0]                 evt_code,
    output logic                       evt_ext,
    output logic                       evt_break,
    output logic                       evt_sys,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    // ---------------- input capture ----------------
    logic       sync0, sync1, sync1_d;
    logic       byte_strobe;
    logic [7:0] byte_q;
    logic       ready_rise;

    assign ready_rise = sync1 & ~sync1_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0       <= 1'b0;
            sync1       <= 1'b0;
            sync1_d     <= 1'b0;
            byte_strobe <= 1'b0;
            byte_q      <= '0;
        end else begin
            sync0       <= scan_ready;
            sync1       <= sync0;
            sync1_d     <= sync1;
            byte_strobe <= ready_rise;
            if (ready_rise)
                byte_q <= scan_code;
        end
    end

    // ---------------- decoder FSM ----------------
    state_t        state, state_nx;
    logic [2:0]    skip, skip_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic          push_req;
    logic [7:0]    push_code;
    logic          push_ext, push_brk, push_sys;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            skip  <= '0;
            tmo   <= '0;
        end else begin
            state <= state_nx;
            skip  <= skip_nx;
            tmo   <= tmo_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        skip_nx   = skip;
        tmo_nx    = '0;
        push_req  = 1'b0;
        push_code = byte_q;
        push_ext  = 1'b0;
        push_brk  = 1'b0;
        push_sys  = 1'b0;

        if (state != S_IDLE)
            tmo_nx = tmo + 1'b1;

        if (byte_strobe) begin
            tmo_nx = '0;
            case (state)
                S_IDLE: begin
                    case (byte_q)
                        8'hE0: state_nx = S_EXT;
                        8'hF0: state_nx = S_BRK;
                        8'hE1: begin
                            state_nx = S_PAUSE;
                            skip_nx  = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                            push_req = 1'b1;
                            push_sys = 1'b1;
                        end
                        default: push_req = 1'b1;
                    endcase
                end
                S_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_nx = S_EXT_BRK;
                    end else begin
                        state_nx = S_IDLE;
                        // E0 12 / E0 59 are fake shifts and carry no key
                        if (byte_q != 8'h12 && byte_q != 8'h59) begin
                            push_req = 1'b1;
                            push_ext = 1'b1;
                        end
                    end
                end
                S_BRK: begin
                    state_nx = S_IDLE;
                    push_req = 1'b1;
                    push_brk = 1'b1;
                end
                S_EXT_BRK: begin
                    state_nx = S_IDLE;
                    if (byte_q != 8'h12 && byte_q != 8'h59) begin
                        push_req = 1'b1;
                        push_ext = 1'b1;
                        push_brk = 1'b1;
                    end
                end
                S_PAUSE: begin
                    // E1 is followed by seven filler bytes; the last one ends the sequence
                    if (skip == 3'd1) begin
                        state_nx  = S_IDLE;
                        skip_nx   = '0;
                        push_req  = 1'b1;
                        push_code = 8'h77;
                        push_ext  = 1'b1;
                    end else begin
                        skip_nx = skip - 3'd1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end else if (state != S_IDLE && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            state_nx = S_IDLE;
            tmo_nx   = '0;
        end
    end

    // ---------------- typematic filter ----------------
    logic push_go;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [7:0] last_code, last_code_nx;
    logic       last_ext, last_ext_nx;
    logic       last_vld, last_vld_nx;
    logic       last_match;

    assign last_match = last_vld && (last_code == push_code) && (last_ext == push_ext);

    always_comb begin
        push_go      = push_req;
        last_code_nx = last_code;
        last_ext_nx  = last_ext;
        last_vld_nx  = last_vld;
        if (push_req && !push_sys) begin
            if (!push_brk) begin
                if (last_match) begin
                    push_go = 1'b0;
                end else begin
                    last_code_nx = push_code;
                    last_ext_nx  = push_ext;
                    last_vld_nx  = 1'b1;
                end
            end else if (last_match) begin
                last_vld_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_code <= '0;
            last_ext  <= 1'b0;
            last_vld  <= 1'b0;
        end else begin
            last_code <= last_code_nx;
            last_ext  <= last_ext_nx;
            last_vld  <= last_vld_nx;
        end
    end
`else
    assign push_go = push_req;
`endif

    // ---------------- event FIFO ----------------
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, push_ok;
    logic [10:0]   head;

    assign full    = (count == CW'(DEPTH));
    assign pop     = (count != '0) && evt_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok = push_go && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {push_code, push_ext, push_brk, push_sys};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_go && full && !pop)
                overflow <= 1'b1;
        end
    end

    // empty FIFO presents zeros rather than a stale entry
    assign head       = mem[rd_ptr];
    assign evt_valid  = (count != '0);
    assign evt_code   = evt_valid ? head[10:3] : '0;
    assign evt_ext    = evt_valid & head[2];
    assign evt_break  = evt_valid & head[1];
    assign evt_sys    = evt_valid & head[0];
    assign fifo_count = count;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder
//   Directed self-checking bench for ps2_scan_decoder. Bytes are presented as
//   scan_ready pulses; results are sampled on the falling clock edge.
//   Honours PS2_TYPEMATIC_FILTER_EN in the same way as the design.
module tb_ps2_scan_decoder;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 40;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   scan_ready;
    logic [7:0]             scan_code;
    logic                   evt_valid;
    logic                   evt_ready;
    logic [7:0]             evt_code;
    logic                   evt_ext;
    logic                   evt_break;
    logic                   evt_sys;
    logic                   overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    ps2_scan_decoder #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .evt_sys    (evt_sys),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_ready = 1'b1;
        repeat (3) @(negedge clk);
        scan_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    // checks the FIFO head, then removes it
    task automatic expect_evt(input string tag, input logic [7:0] code,
                              input logic ext, input logic brk, input logic sys);
        check({tag, "_valid"}, evt_valid, 1'b1);
        check({tag, "_code"}, evt_code, code);
        check({tag, "_flags"}, {evt_ext, evt_break, evt_sys}, {ext, brk, sys});
        pop_one();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pause_seq [8];
        reset      = 1'b1;
        scan_ready = 1'b0;
        scan_code  = '0;
        evt_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_code", {evt_code, evt_ext, evt_break, evt_sys}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // latency: valid appears on the 4th cycle and lasts one cycle with ready high
        @(negedge clk);
        scan_code  = 8'h1C;
        scan_ready = 1'b1;
        evt_ready  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("lat_valid_c%0d", c), evt_valid, (c == 4));
            if (c == 4)
                check("lat_evt", {evt_code, evt_ext, evt_break, evt_sys}, {8'h1C, 3'b000});
        end
        scan_ready = 1'b0;
        evt_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("lat_count", fifo_count, 0);

        // extended break
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check("extbrk_count", fifo_count, 1);
        expect_evt("extbrk", 8'h75, 1'b1, 1'b1, 1'b0);

        // fake shifts produce nothing
        send_byte(8'hE0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h59);
        check("fake_count", fifo_count, 0);

        send_byte(8'hE0); send_byte(8'h75);
        expect_evt("extmake", 8'h75, 1'b1, 1'b0, 1'b0);

        send_byte(8'hAA);
        expect_evt("sys", 8'hAA, 1'b0, 1'b0, 1'b1);
        send_byte(8'hF0); send_byte(8'hAA);
        expect_evt("brk_aa", 8'hAA, 1'b0, 1'b1, 1'b0);

        // pause sequence
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++)
            send_byte(pause_seq[i]);
        check("pause_count", fifo_count, 1);
        expect_evt("pause", 8'h77, 1'b1, 1'b0, 1'b0);

        // fill, overflow, simultaneous push/pop while full
        for (int i = 0; i < 8; i++)
            send_byte(8'h15 + 8'(i));
        check("fill_count", fifo_count, 8);
        check("fill_ovf", overflow, 1'b0);
        send_byte(8'h1D); send_byte(8'h1E);
        check("ovf_count", fifo_count, 8);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_head", evt_code, 8'h15);
        @(negedge clk);
        scan_code  = 8'h1F;
        scan_ready = 1'b1;
        repeat (3) @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready  = 1'b0;
        scan_ready = 1'b0;
        check("pp_count", fifo_count, 8);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++)
            expect_evt($sformatf("drain%0d", i), 8'h16 + 8'(i), 1'b0, 1'b0, 1'b0);
        expect_evt("drain_last", 8'h1F, 1'b0, 1'b0, 1'b0);
        check("drain_count", fifo_count, 0);
        check("drain_ovf", overflow, 1'b1);

        // break prefix abandoned after the timeout
        send_byte(8'hF0);
        repeat (TMO + 10) @(negedge clk);
        send_byte(8'h1C);
        expect_evt("tmo", 8'h1C, 1'b0, 1'b0, 1'b0);

        // short gap keeps the prefix
        send_byte(8'hF0);
        repeat (10) @(negedge clk);
        send_byte(8'h1C);
        expect_evt("notmo", 8'h1C, 1'b0, 1'b1, 1'b0);

        // reset loses a partial prefix
        send_byte(8'hE0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_count", fifo_count, 0);
        check("midrst_ovf", overflow, 1'b0);
        send_byte(8'h75);
        expect_evt("midrst", 8'h75, 1'b0, 1'b0, 1'b0);

        // auto-repeat
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("typ_count", fifo_count, 3);
        expect_evt("typ_make0", 8'h1C, 1'b0, 1'b0, 1'b0);
        expect_evt("typ_brk", 8'h1C, 1'b0, 1'b1, 1'b0);
        expect_evt("typ_make1", 8'h1C, 1'b0, 1'b0, 1'b0);
`else
        check("typ_count", fifo_count, 5);
        for (int i = 0; i < 3; i++)
            expect_evt($sformatf("typ_make%0d", i), 8'h1C, 1'b0, 1'b0, 1'b0);
        expect_evt("typ_brk", 8'h1C, 1'b0, 1'b1, 1'b0);
        expect_evt("typ_make3", 8'h1C, 1'b0, 1'b0, 1'b0);
`endif
        check("typ_empty", fifo_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Sits between the PS/2 receiver (scan_ready/scan_code, PS/2-clock domain) and system logic on the system clock.
- Synchronises the receiver's ready flag and captures each byte.
- Folds the prefix bytes E0 (extended), F0 (break) and the E1 pause sequence into single key events.
- Buffers events in a FIFO with a valid/ready handshake.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 50000, clk cycles allowed between bytes of one multi-byte sequence before the decoder abandons it (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- scan_ready  input  1  receiver byte-valid level; asynchronous to clk
- scan_code  input  8  receiver byte; stable while scan_ready is high
- evt_valid  output  1  FIFO head holds an event
- evt_ready  input  1  consumer accepts head when evt_valid && evt_ready
- evt_code  output  8  key code (prefixes stripped)
- evt_ext  output  1  event was E0-prefixed
- evt_break  output  1  key release
- evt_sys  output  1  device/system byte, not a key
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- fifo_count  output  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (async): all FIFO pointers and fifo_count = 0; evt_valid = 0; evt_code = 0, evt_ext = 0, evt_break = 0, evt_sys = 0; overflow = 0; FSM in IDLE; synchroniser flops = 0; timeout counter = 0.
- Input capture:
  - scan_ready passes through a 2-flop synchroniser, then a rising-edge detect.
  - On the edge cycle, scan_code is sampled into a byte register.
  - The FSM processes that byte on the next cycle ("byte strobe").
  - No edge means no byte. A level held high is one byte only.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - IDLE, E0: go to EXT.
  - IDLE, F0: go to BRK.
  - IDLE, E1: go to PAUSE with skip counter = 7.
  - IDLE, one of AA/FA/FE/EE/00/FF: push {code, ext=0, brk=0, sys=1}.
  - IDLE, any other byte: push {code, 0, 0, 0}.
  - EXT, F0: go to EXT_BRK.
  - EXT, 12 or 59 (fake shift): discard, go to IDLE.
  - EXT, any other byte: push {code, 1, 0, 0}, go to IDLE.
  - BRK, any byte: push {code, 0, 1, 0}, go to IDLE.
  - EXT_BRK, 12 or 59: discard, go to IDLE.
  - EXT_BRK, any other byte: push {code, 1, 1, 0}, go to IDLE.
  - PAUSE: each byte decrements the skip counter. When it reaches 0, push {77, 1, 0, 0} and go to IDLE.
- Timeout:
  - In any non-IDLE state the counter increments each cycle and clears on each byte strobe.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE with no push and clears the counter.
  - The counter is held at 0 in IDLE.
- FIFO:
  - First-word fall-through: evt_* outputs show the head entry. evt_valid = (count != 0).
  - Pop when evt_valid && evt_ready.
  - Push when not full, or when full and a pop occurs in the same cycle; that push is accepted.
  - Push while full with no pop: event dropped, overflow set. overflow clears only on reset.
  - Push and pop in the same cycle: count unchanged.
  - Pop on empty: ignored.
  - Pointers wrap modulo DEPTH.
- Latency: a scan_ready rising edge reaches evt_valid on an empty FIFO 4 clk cycles later (2 sync, 1 capture, 1 FSM/push).
- Reset mid-sequence: the partial prefix state is lost and no event is emitted.

Optional Feature:
- Macro PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - The decoder keeps a last-make register {code, ext, valid}.
  - A make event equal to it is not pushed (auto-repeat suppressed).
  - A break with matching code/ext clears valid.
  - A differing make replaces it.
  - sys events do not affect it.
  - Reset clears valid.
- Undefined: every make event is pushed. The register is absent.

Test Plan:
- Byte 1C, evt_ready=1 -> one event {1C,0,0,0}, evt_valid high for exactly 1 cycle, 4 cycles after the scan_ready edge.
- Sequence E0 F0 75 -> single event {75, ext=1, brk=1}. Sequence E0 12 -> no event.
- E1 14 77 E1 F0 14 F0 77 -> single event {77,1,0,0}, fifo_count=1.
- evt_ready=0, 10 bytes 15..1E with DEPTH=8 -> fifo_count=8, overflow=1. Drain yields 15..1C in order. Simultaneous push/pop at full is accepted.
- F0 then no byte for TIMEOUT_CYCLES -> FSM back in IDLE. Next byte 1C -> make event {1C,0,0,0}, not a break.
- With PS2_TYPEMATIC_FILTER_EN: 1C 1C 1C F0 1C 1C -> events make 1C, break 1C, make 1C. Without it: 4 makes and 1 break.
